// File: rtl/light_seq_if.sv
// light_seq_if: code stream in, lamp drives and supervisor status out
interface light_seq_if #(parameter int ERR_W = 8);
    logic [3:0]       code_in;
    logic             clr_err;
    logic [2:0]       lamp_a;
    logic [2:0]       lamp_b;
    logic             locked;
    logic             seq_err;
    logic             lane_mismatch;
    logic             stall;
    logic [ERR_W-1:0] err_count;
    modport master (output code_in, clr_err,
                    input  lamp_a, lamp_b, locked, seq_err, lane_mismatch, stall, err_count);
    modport slave  (input  code_in, clr_err,
                    output lamp_a, lamp_b, locked, seq_err, lane_mismatch, stall, err_count);
endinterface

// File: rtl/light_sequence_monitor.sv
// light_sequence_monitor: syncs the two light-code lanes, drives lamps and checks
// the 00->01->10->00 cycle, reporting sequence errors, lane mismatch and stalls.
module light_sequence_monitor #(
    parameter int                 STALL_W      = 24,
    parameter logic [STALL_W-1:0] STALL_LIMIT  = STALL_W'(12_000_000),
    parameter int                 MISMATCH_TOL = 3,
    parameter int                 ERR_W        = 8
) (
    input logic        clk,
    input logic        reset,
    light_seq_if.slave bus
);
    localparam logic [0:0] ST_ACQUIRE = 1'b0;
    localparam logic [0:0] ST_TRACK   = 1'b1;
    localparam int         MW         = $clog2(MISMATCH_TOL + 2);
    localparam logic [MW-1:0] TOL     = MW'(MISMATCH_TOL);

    function automatic logic legal(input logic [1:0] p, input logic [1:0] c);
        return (p == 2'b00 && c == 2'b01) || (p == 2'b01 && c == 2'b10) || (p == 2'b10 && c == 2'b00);
    endfunction

    function automatic logic [2:0] lamp(input logic [1:0] c);
        return c == 2'b00 ? 3'b100 : c == 2'b01 ? 3'b001 : c == 2'b10 ? 3'b010 : 3'b000;
    endfunction

    logic [3:0]         r_sync1, r_sync2;
    logic [1:0]         r_prev_a, r_prev_b;
    logic [2:0]         r_lamp_a, r_lamp_b;
    logic [0:0]         r_state;
    logic [1:0]         r_acq;
    logic [STALL_W-1:0] r_dwell;
    logic [MW-1:0]      r_mm_cnt;
    logic               r_mm_done;
    logic               r_seq_err, r_mismatch, r_stall;
    logic [ERR_W-1:0]   r_err_cnt;

    logic [1:0]         w_sa, w_sb;
    logic               w_ev_a, w_ev_b, w_track, w_disagree, w_legal_a;
    logic               w_seq_ev, w_mm_ev, w_stall_ev, w_any;
    logic [STALL_W-1:0] w_dwell_inc;

    assign w_sa        = r_sync2[1:0];
    assign w_sb        = r_sync2[3:2];
    assign w_ev_a      = w_sa != r_prev_a;
    assign w_ev_b      = w_sb != r_prev_b;
    assign w_legal_a   = legal(r_prev_a, w_sa);
    assign w_track     = r_state == ST_TRACK;
    assign w_disagree  = w_sa != w_sb;
    assign w_dwell_inc = r_dwell + STALL_W'(1);
    assign w_seq_ev    = w_track & ((w_ev_a & ~w_legal_a) | (w_ev_b & ~legal(r_prev_b, w_sb)));
    // one mismatch event per episode: r_mm_done holds until the lanes agree again
    assign w_mm_ev     = w_track & w_disagree & ~r_mm_done & (r_mm_cnt >= TOL);
    assign w_stall_ev  = w_track & ~w_ev_a & (w_dwell_inc == STALL_LIMIT);
    assign w_any       = w_seq_ev | w_mm_ev | w_stall_ev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev_a   <= '0;
            r_prev_b   <= '0;
            r_lamp_a   <= 3'b100;
            r_lamp_b   <= 3'b100;
            r_state    <= ST_ACQUIRE;
            r_acq      <= '0;
            r_dwell    <= '0;
            r_mm_cnt   <= '0;
            r_mm_done  <= 1'b0;
            r_seq_err  <= 1'b0;
            r_mismatch <= 1'b0;
            r_stall    <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_sync1    <= bus.code_in;
            r_sync2    <= r_sync1;
            r_prev_a   <= w_sa;
            r_prev_b   <= w_sb;
            r_lamp_a   <= lamp(w_sa);
            r_lamp_b   <= lamp(w_sb);
            r_mm_cnt   <= !w_disagree ? '0 : r_mm_cnt < TOL ? r_mm_cnt + MW'(1) : r_mm_cnt;
            r_mm_done  <= w_disagree & (r_mm_done | w_mm_ev);
            r_seq_err  <= (r_seq_err & ~bus.clr_err) | w_seq_ev;
            r_mismatch <= (r_mismatch & ~bus.clr_err) | w_mm_ev;
            r_stall    <= (r_stall & ~bus.clr_err) | w_stall_ev;
            r_err_cnt  <= bus.clr_err ? ERR_W'(w_any) : r_err_cnt + ERR_W'(w_any && ~&r_err_cnt);
            if (w_track) begin
                r_state <= (w_seq_ev | w_stall_ev) ? ST_ACQUIRE : ST_TRACK;
                r_dwell <= (w_seq_ev | w_stall_ev | w_ev_a) ? '0 : w_dwell_inc;
                r_acq   <= '0;
            end else if (w_ev_a) begin
                r_state <= (w_legal_a && r_acq == 2'd1) ? ST_TRACK : ST_ACQUIRE;
                r_acq   <= (w_legal_a && r_acq != 2'd1) ? r_acq + 2'd1 : 2'd0;
                r_dwell <= '0;
            end
        end
    end

    assign bus.lamp_a        = r_lamp_a;
    assign bus.lamp_b        = r_lamp_b;
    assign bus.locked        = w_track;
    assign bus.seq_err       = r_seq_err;
    assign bus.lane_mismatch = r_mismatch;
    assign bus.stall         = r_stall;
    assign bus.err_count     = r_err_cnt;
endmodule

// File: tb/tb_light_sequence_monitor.sv
// tb_light_sequence_monitor: directed plan steps plus random code streams against a behavioural model
module tb_light_sequence_monitor;
    localparam int STALL_W = 24;
    localparam int LIMIT   = 50;
    localparam int TOL     = 3;
    localparam int ERR_W   = 8;
    localparam int MAXC    = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    light_seq_if #(.ERR_W(ERR_W)) bus();

    light_sequence_monitor #(
        .STALL_W(STALL_W), .STALL_LIMIT(STALL_W'(LIMIT)), .MISMATCH_TOL(TOL), .ERR_W(ERR_W)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [2:0] lamp_tbl [4] = '{3'b100, 3'b001, 3'b010, 3'b000};
    logic [3:0] hist [$];
    int m_pa, m_pb, m_acq, m_idle, m_run, m_cnt;
    bit m_locked, m_flagged, m_seq, m_mm, m_stall;
    logic [2:0] m_lamp_a, m_lamp_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int succ(input int p);
        return p == 3 ? -1 : (p + 1) % 3;
    endfunction

    task automatic model_reset();
        hist = '{4'h0, 4'h0};
        {m_pa, m_pb, m_acq, m_idle, m_run, m_cnt} = '0;
        {m_locked, m_flagged, m_seq, m_mm, m_stall} = '0;
        m_lamp_a = 3'b100;
        m_lamp_b = 3'b100;
    endtask

    // one rising edge: the lane codes seen now are the inputs from two edges ago
    task automatic model_edge(input logic [3:0] x, input bit clr);
        int sa, sb;
        bit eva, evb, seq, mm, st, any;
        sa = int'(hist[0][1:0]);
        sb = int'(hist[0][3:2]);
        void'(hist.pop_front());
        hist.push_back(x);
        eva   = sa != m_pa;
        evb   = sb != m_pb;
        m_run = sa != sb ? m_run + 1 : 0;
        seq   = m_locked && ((eva && sa != succ(m_pa)) || (evb && sb != succ(m_pb)));
        mm    = m_locked && m_run > TOL && !m_flagged;
        st    = m_locked && !eva && m_idle + 1 == LIMIT;
        any   = seq || mm || st;
        m_flagged = m_run > 0 && (m_flagged || mm);
        m_seq   = (m_seq && !clr) || seq;
        m_mm    = (m_mm && !clr) || mm;
        m_stall = (m_stall && !clr) || st;
        m_cnt   = clr ? int'(any) : (any && m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
        if (m_locked) begin
            if (seq || st) begin
                m_locked = 0;
                m_acq    = 0;
                m_idle   = 0;
            end else m_idle = eva ? 0 : m_idle + 1;
        end else if (eva) begin
            m_acq = sa == succ(m_pa) ? m_acq + 1 : 0;
            if (m_acq == 2) begin
                m_locked = 1;
                m_acq    = 0;
                m_idle   = 0;
            end
        end
        m_lamp_a = lamp_tbl[sa];
        m_lamp_b = lamp_tbl[sb];
        m_pa = sa;
        m_pb = sb;
    endtask

    task automatic check_all();
        chk("lamp_a", bus.lamp_a, m_lamp_a);
        chk("lamp_b", bus.lamp_b, m_lamp_b);
        chk("locked", bus.locked, m_locked);
        chk("seq_err", bus.seq_err, m_seq);
        chk("lane_mismatch", bus.lane_mismatch, m_mm);
        chk("stall", bus.stall, m_stall);
        chk("err_count", bus.err_count, m_cnt);
    endtask

    task automatic step(input logic [3:0] code, input bit clr);
        @(negedge clk);
        check_all();
        bus.code_in = code;
        bus.clr_err = clr;
        model_edge(code, clr);
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        repeat (n) step(code, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_lamp_a", bus.lamp_a, 3'b100);
        chk("rst_lamp_b", bus.lamp_b, 3'b100);
        chk("rst_locked", bus.locked, 1'b0);
        chk("rst_flags", {bus.seq_err, bus.lane_mismatch, bus.stall}, 3'b000);
        chk("rst_err_count", bus.err_count, 0);
        bus.code_in = 4'h0;
        bus.clr_err = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int a, b, an, bn, lag, h;
        bus.code_in = 4'h0;
        bus.clr_err = 1'b0;
        model_reset();
        do_reset();
        hold(4'b0000, 30); hold(4'b0101, 30); hold(4'b1010, 30); hold(4'b0000, 30);
        chk("lock_after_cycle", bus.locked, 1'b1);
        chk("clean_count", bus.err_count, 0);
        hold(4'b0101, 20);
        hold(4'b0000, 10);
        chk("illegal_seq_err", bus.seq_err, 1'b1);
        chk("illegal_unlock", bus.locked, 1'b0);
        chk("illegal_count", bus.err_count, 1);
        hold(4'b0101, 10); hold(4'b1010, 10);
        chk("relock", bus.locked, 1'b1);
        step(4'b1010, 1'b1);
        hold(4'b1111, 10);
        chk("dark_lamp", bus.lamp_a, 3'b000);
        chk("dual_illegal_count", bus.err_count, 1);
        hold(4'b0000, 10); hold(4'b0101, 10); hold(4'b1010, 10);
        hold(4'b1000, 2); hold(4'b0000, 10);
        chk("lag2_no_flag", bus.lane_mismatch, 1'b0);
        hold(4'b0001, 5); hold(4'b0101, 10);
        chk("lag5_flag", bus.lane_mismatch, 1'b1);
        chk("lag5_locked", bus.locked, 1'b1);
        chk("lag5_count", bus.err_count, 2);
        hold(4'b0101, 60);
        chk("stall_flag", bus.stall, 1'b1);
        chk("stall_unlock", bus.locked, 1'b0);
        hold(4'b1010, 10); hold(4'b0000, 10);
        step(4'b1010, 1'b0); step(4'b1010, 1'b0); step(4'b1010, 1'b1);
        hold(4'b1010, 5);
        chk("clr_vs_event_flag", bus.seq_err, 1'b1);
        chk("clr_vs_event_count", bus.err_count, 1);
        hold(4'b0000, 10); hold(4'b0101, 10);
        a = 1;
        for (int i = 0; i < 260; i++) begin
            an = succ(a);
            hold({2'(a), 2'(an)}, 5);
            hold({2'(an), 2'(an)}, 3);
            a = an;
        end
        chk("saturated", bus.err_count, MAXC);
        chk("sat_locked", bus.locked, 1'b1);
        do_reset();
        a = 0;
        b = 0;
        for (int s = 0; s < 300; s++) begin
            an  = ($urandom % 16 == 0 || a == 3) ? int'($urandom % 4) : succ(a);
            bn  = ($urandom % 12 == 0) ? int'($urandom % 4) : an;
            lag = $urandom_range(0, 6);
            h   = $urandom_range(lag + 1, 70);
            for (int i = 0; i < h; i++)
                step(i < lag ? {2'(b), 2'(an)} : {2'(bn), 2'(an)}, $urandom % 40 == 0);
            a = an;
            b = bn;
        end
        @(negedge clk);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/light_sequence_monitor.md
Name: light_sequence_monitor

Overview:
- Receiving end of the 3-state light controller's code stream. Consumes the two 2-bit state-code lanes, which change on a slow divided clock, in the fast system clock domain.
- Synchronises the lanes, decodes them to one-hot lamp drives and checks the legal cycle 00->01->10->00.
- Flags illegal codes, lane disagreement and stalls, and keeps a saturating error count for the supervisor.

Parameters:
- STALL_W, 24, width of the dwell counter.
- STALL_LIMIT, 24'd12_000_000, number of consecutive clk cycles with no lane-A transition that counts as a stall.
- MISMATCH_TOL, 3, number of consecutive cycles lanes A and B may disagree before lane_mismatch is raised.
- ERR_W, 8, width of err_count.

Ports:
- clk  in  1  system clock, fast domain, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- code_in  in  4  [1:0] lane A, [3:2] lane B; asynchronous to clk.
- clr_err  in  1  synchronous one-cycle pulse; clears sticky flags and err_count.
- lamp_a  out  3  {red, yellow, green} for lane A.
- lamp_b  out  3  {red, yellow, green} for lane B.
- locked  out  1  monitor is tracking a legal sequence.
- seq_err  out  1  sticky: illegal code or illegal transition seen.
- lane_mismatch  out  1  sticky: lanes disagreed longer than MISMATCH_TOL.
- stall  out  1  sticky: no lane-A transition within STALL_LIMIT cycles while locked.
- err_count  out  ERR_W  saturating count of error events.

Behaviour:
- Reset (async assert, state held while high):
  - Synchroniser flops and prev codes = 00.
  - lamp_a = lamp_b = 3'b100 (red).
  - locked = 0, all flags = 0, err_count = 0, dwell = 0, FSM = ACQUIRE.
- Synchroniser: two flops per bit. The synchronised code (s_a, s_b) is valid 2 clk after a code_in change. Lamps and checks use s_a/s_b, so the total latency from code_in to lamp is 3 clk.
- Lamp decode, registered:
  - 00 -> 100 (red)
  - 01 -> 001 (green)
  - 10 -> 010 (yellow)
  - 11 -> 000 (dark); also an illegal code.
- Transition detection per lane:
  - An event occurs when s != prev. On an event, prev <= s.
  - Legal successors: 00->01, 01->10, 10->00. Anything else is illegal.
  - Holding the same code is not an event.
- FSM:
  - ACQUIRE: locked = 0.
    - Count consecutive legal lane-A events in a 2-bit counter.
    - An illegal event resets the counter to 0 and is not counted as an error.
    - When the counter reaches 2, go to TRACK.
  - TRACK: locked = 1.
    - dwell increments each cycle and clears on every lane-A event.
    - Error events:
      - an illegal transition or code 11 on either lane -> set seq_err;
      - s_a != s_b for more than MISMATCH_TOL consecutive cycles -> set lane_mismatch, once per disagreement episode;
      - dwell reaching STALL_LIMIT -> set stall.
    - seq_err or stall -> go to ACQUIRE, with dwell and the acquire counter cleared.
    - lane_mismatch does not leave TRACK.
- err_count:
  - +1 per cycle in which at least one error event occurs. Simultaneous events add 1 only.
  - Saturates at all-ones.
- clr_err:
  - Clears seq_err, lane_mismatch, stall and err_count. The FSM is not affected.
  - If clr_err and an error event occur in the same cycle, the event wins: the flag is 1 and err_count = 1.
- Reset asserted mid-sequence: all state returns to reset values immediately. After release, re-acquisition needs 2 legal lane-A events.

Test Plan:
- Reset, then drive code_in = 4'b0000, 0101, 1010, 0000, each held 100 clk -> lamps red, green, yellow, red with 3-clk latency; locked = 1 after the 0101->1010 change reaches s_a; all flags 0; err_count 0.
- While locked at 0101, drive code_in = 4'b0000 (01->00 illegal) -> seq_err = 1, err_count = 1, locked = 0; two further legal steps -> locked = 1 again.
- While locked, drive lane A = 11 -> lamp_a = 000, seq_err = 1. In the same cycle lane B also goes illegal -> err_count increments by 1 only.
- While locked, lane B lags lane A by 2 clk -> no flag. Lag of 5 clk with MISMATCH_TOL = 3 -> lane_mismatch = 1, err_count +1, locked stays 1.
- STALL_LIMIT = 50, hold code after lock -> stall = 1 on the 50th idle cycle, locked = 0. Pulse clr_err on the same cycle as a new illegal event -> seq_err = 1, err_count = 1.
- Force 255 errors with ERR_W = 8, then one more -> err_count stays 255. Assert reset mid-TRACK -> all outputs at reset values within the same cycle.
